stq_buffer: RTL and testbench
=============================

Name: stq_buffer

Overview:
- Circular store queue between dispatch and the data cache.
- Allocates stores in program order, captures addresses from the AGU and store data from the CDB, and holds them until ROB commit.
- Drains committed stores to the cache in order.
- Answers store-to-load forwarding lookups from the load reservation station.

Parameters:
STQ_DEPTH, 8, number of entries (power of 2, >=2)
TAG_W, 6, ROB/physical destination tag width
PIPE_WIDTH, 4, number of CDB ports
XLEN, 32, address/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; drops all uncommitted entries
cache_stall  in  1  cache busy; blocks drain
alloc_valid  in  1  dispatch allocates one store
alloc_tag  in  TAG_W  store's ROB tag (used to match AGU results)
alloc_data_tag  in  TAG_W  producer tag of store data
alloc_data_ready  in  1  store data already available
alloc_data  in  XLEN  store data when ready
alloc_rdy  out  1  queue not full
agu_valid  in  1  AGU address result valid
agu_tag  in  TAG_W  tag of the store receiving the address
agu_addr  in  XLEN  computed effective address
cdb_valid  in  PIPE_WIDTH  per-port CDB valid
cdb_tag  in  PIPE_WIDTH*TAG_W  per-port CDB tags
cdb_data  in  PIPE_WIDTH*XLEN  per-port CDB results
commit_valid  in  1  ROB retires the oldest uncommitted store
mem_req_valid  out  1  store request to cache
mem_req_addr  out  XLEN  word address of the head store
mem_req_data  out  XLEN  data of the head store
mem_req_ready  in  1  cache accepts the request
fwd_addr  in  XLEN  load address probe
fwd_hit  out  1  matching store found with data ready
fwd_data  out  XLEN  forwarded data
fwd_pending  out  1  matching store found but its data is not ready; load must wait
count  out  $clog2(STQ_DEPTH)+1  occupied entries

Behaviour:
- Storage per entry: valid, addr_rdy, addr, data_rdy, data_tag, data, committed, tag.
- Pointers: head (oldest), commit_ptr (oldest uncommitted), tail (next free). Each pointer has an extra wrap bit so full and empty are distinguishable.
- Reset:
  - All entry valid bits clear; head = commit_ptr = tail = 0.
  - Outputs: alloc_rdy=1, mem_req_valid=0, fwd_hit=0, fwd_pending=0, count=0.
- Allocation:
  - When alloc_valid && alloc_rdy && !flush, write entry[tail] and advance tail.
  - alloc_rdy = !full, computed from registered pointers only; no same-cycle bypass from a pop. alloc_valid while full is ignored.
- Data capture:
  - Each cycle, every valid entry with !data_rdy compares data_tag against all PIPE_WIDTH CDB ports. On a match, latch the data and set data_rdy.
  - An entry allocated this cycle also snoops the CDB with alloc_data_tag, so a same-cycle result is not lost.
  - Multiple port matches: the lowest port index wins.
- Address capture:
  - agu_valid sets addr and addr_rdy on the valid entry whose tag == agu_tag.
  - A same-cycle alloc of that tag is also captured.
  - No matching entry: ignored.
- Commit:
  - commit_valid marks entry[commit_ptr] committed and advances commit_ptr.
  - commit_valid when commit_ptr == tail is a protocol error: ignored.
- Drain:
  - mem_req_valid = entry[head].valid && committed && addr_rdy && data_rdy && !cache_stall.
  - mem_req_addr = {addr[XLEN-1:2], 2'b00}.
  - On mem_req_valid && mem_req_ready: clear entry[head] and advance head. Latency is 0 cycles from the head becoming eligible.
- Flush:
  - Invalidate every entry from commit_ptr up to tail-1; set tail to commit_ptr after this cycle's commit.
  - Committed entries survive and keep draining.
  - Alloc in the same cycle is dropped. A drain in the same cycle proceeds.
- Forwarding (combinational):
  - Compare fwd_addr[XLEN-1:2] against every valid, addr_rdy entry.
  - Select the youngest match, searching from tail-1 back to head.
  - Youngest match data_rdy: fwd_hit=1 and fwd_data = its data.
  - Youngest match not data_rdy: fwd_pending=1.
  - No match: both 0.
- Wrap-around: all pointers increment modulo STQ_DEPTH and toggle their wrap bit.
- count = tail - head, taken from the full pointers including wrap bits.
- Reset mid-operation: all state is discarded next cycle, including committed stores that have not drained.

Test Plan:
- Alloc tag 3 with data_ready=1, data 0xAA; AGU tag 3 addr 0x100; commit; mem_req_ready=1 -> mem_req_valid the cycle after commit with addr 0x100, data 0xAA; count returns to 0.
- Fill 8 entries -> alloc_rdy=0; a 9th alloc is ignored; drain one -> alloc_rdy=1 the next cycle; run 20 alloc/drain cycles -> order preserved across wrap.
- Alloc with data_tag 7 not ready; CDB port 2 broadcasts tag 7, data 0x55 -> data_rdy set; same test with the CDB broadcast in the alloc cycle -> still captured.
- Two stores to 0x200 (data 1 then 2), both with address ready; probe 0x202 -> fwd_hit=1, fwd_data=2. Younger store's data not ready -> fwd_pending=1, fwd_hit=0.
- 4 entries allocated, 2 committed, flush asserted with a simultaneous alloc -> count=2, alloc dropped, the 2 committed stores drain.
- cache_stall=1 with an eligible head -> mem_req_valid=0; deassert -> request issued.

Source files
------------

// File: rtl/stq_buffer.sv
// ----------------------------------------------------------------------------
// stq_buffer
// Circular store queue sitting between dispatch and the data cache.
//   - Stores are allocated in program order at the tail.
//   - Effective addresses arrive from the AGU (matched by ROB tag).
//   - Store data arrives either at allocation or later from the CDB
//     (matched by producer tag).
//   - The ROB commits stores in order (commit_ptr); committed, fully
//     resolved stores drain from the head to the cache.
//   - A flush drops every uncommitted entry; committed stores keep draining.
//   - Loads probe the queue for store-to-load forwarding (youngest match).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               mispredict flush (drops uncommitted entries)
//   cache_stall         blocks the drain request
//   alloc_*             dispatch allocation interface, alloc_rdy = not full
//   agu_*               address results
//   cdb_*               PIPE_WIDTH result broadcast ports (packed per port)
//   commit_valid        ROB retires the oldest uncommitted store
//   mem_req_*           store request to the cache (valid/ready)
//   fwd_*               forwarding probe and result
//   count               number of occupied entries
// ----------------------------------------------------------------------------
module stq_buffer #(
    parameter int STQ_DEPTH  = 8,
    parameter int TAG_W      = 6,
    parameter int PIPE_WIDTH = 4,
    parameter int XLEN       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       cache_stall,
    input  logic                       alloc_valid,
    input  logic [TAG_W-1:0]           alloc_tag,
    input  logic [TAG_W-1:0]           alloc_data_tag,
    input  logic                       alloc_data_ready,
    input  logic [XLEN-1:0]            alloc_data,
    output logic                       alloc_rdy,
    input  logic                       agu_valid,
    input  logic [TAG_W-1:0]           agu_tag,
    input  logic [XLEN-1:0]            agu_addr,
    input  logic [PIPE_WIDTH-1:0]      cdb_valid,
    input  logic [PIPE_WIDTH*TAG_W-1:0] cdb_tag,
    input  logic [PIPE_WIDTH*XLEN-1:0] cdb_data,
    input  logic                       commit_valid,
    output logic                       mem_req_valid,
    output logic [XLEN-1:0]            mem_req_addr,
    output logic [XLEN-1:0]            mem_req_data,
    input  logic                       mem_req_ready,
    input  logic [XLEN-1:0]            fwd_addr,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
    output logic                       fwd_pending,
    output logic [$clog2(STQ_DEPTH):0] count
);

    localparam int IDX_W = $clog2(STQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Clears the byte offset so stores and loads compare at word granularity.
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Searches the CDB for a tag; the lowest matching port wins because it is
    // visited last. Returns {hit, data}.
    function automatic logic [XLEN:0] cdb_snoop(
        input logic [TAG_W-1:0]            tag,
        input logic [PIPE_WIDTH-1:0]       valid,
        input logic [PIPE_WIDTH*TAG_W-1:0] tags,
        input logic [PIPE_WIDTH*XLEN-1:0]  datas
    );
        logic [XLEN:0] res;
        res = {1'b0, {XLEN{1'b0}}};
        for (int p = PIPE_WIDTH - 1; p >= 0; p--) begin
            if (valid[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, datas[p*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]     tail_q, tail_d;

    logic [STQ_DEPTH-1:0] valid_q, valid_d;
    logic [STQ_DEPTH-1:0] addr_rdy_q, addr_rdy_d;
    logic [STQ_DEPTH-1:0] data_rdy_q, data_rdy_d;
    logic [STQ_DEPTH-1:0] committed_q, committed_d;
    logic [XLEN-1:0]      addr_q [STQ_DEPTH];
    logic [XLEN-1:0]      addr_d [STQ_DEPTH];
    logic [XLEN-1:0]      data_q [STQ_DEPTH];
    logic [XLEN-1:0]      data_d [STQ_DEPTH];
    logic [TAG_W-1:0]     data_tag_q [STQ_DEPTH];
    logic [TAG_W-1:0]     data_tag_d [STQ_DEPTH];
    logic [TAG_W-1:0]     tag_q [STQ_DEPTH];
    logic [TAG_W-1:0]     tag_d [STQ_DEPTH];

    logic [IDX_W-1:0]     head_idx_s;
    logic [IDX_W-1:0]     commit_idx_s;
    logic [IDX_W-1:0]     tail_idx_s;
    logic                 full_s;
    logic                 alloc_fire_s;
    logic                 commit_ok_s;
    logic                 drain_fire_s;
    logic                 mem_req_valid_s;
    logic [XLEN:0]        alloc_snoop_s;

    assign head_idx_s   = head_q[IDX_W-1:0];
    assign commit_idx_s = commit_ptr_q[IDX_W-1:0];
    assign tail_idx_s   = tail_q[IDX_W-1:0];

    // Same slot with opposite wrap bits means the tail lapped the head.
    assign full_s = (tail_idx_s == head_idx_s) && (tail_q[IDX_W] != head_q[IDX_W]);

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    // Head drain request and occupancy; valid, addr and data come straight
    // from the head entry so an eligible head is offered without delay.
    always_comb begin
        mem_req_valid_s = valid_q[head_idx_s] && committed_q[head_idx_s] &&
                          addr_rdy_q[head_idx_s] && data_rdy_q[head_idx_s] &&
                          !cache_stall;
        mem_req_valid   = mem_req_valid_s;
        mem_req_addr    = addr_q[head_idx_s] & WORD_MASK;
        mem_req_data    = data_q[head_idx_s];
        alloc_rdy       = !full_s;
        count           = tail_q - head_q;
    end

    // Forwarding search: walk oldest to youngest so the last match seen
    // is the youngest store to the probed word.
    always_comb begin : fwd_search
        logic                 found;
        logic [IDX_W-1:0]     sel;
        logic [IDX_W-1:0]     idx;
        found = 1'b0;
        sel   = {IDX_W{1'b0}};
        idx   = {IDX_W{1'b0}};
        for (int k = 0; k < STQ_DEPTH; k++) begin
            idx = head_idx_s + IDX_W'(k);
            if (valid_q[idx] && addr_rdy_q[idx] &&
                ((addr_q[idx] & WORD_MASK) == (fwd_addr & WORD_MASK))) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        fwd_hit     = found && data_rdy_q[sel];
        fwd_pending = found && !data_rdy_q[sel];
        if (found && data_rdy_q[sel]) begin
            fwd_data = data_q[sel];
        end else begin
            fwd_data = {XLEN{1'b0}};
        end
    end

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    // Applies capture, commit, allocate, drain and flush in that order so
    // that a same-cycle commit survives the flush.
    always_comb begin
        head_d       = head_q;
        commit_ptr_d = commit_ptr_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        addr_rdy_d   = addr_rdy_q;
        data_rdy_d   = data_rdy_q;
        committed_d  = committed_q;
        addr_d       = addr_q;
        data_d       = data_q;
        data_tag_d   = data_tag_q;
        tag_d        = tag_q;

        alloc_fire_s  = alloc_valid && !full_s && !flush;
        commit_ok_s   = commit_valid && (commit_ptr_q != tail_q);
        drain_fire_s  = mem_req_valid_s && mem_req_ready;
        alloc_snoop_s = cdb_snoop(alloc_data_tag, cdb_valid, cdb_tag, cdb_data);

        for (int i = 0; i < STQ_DEPTH; i++) begin : capture
            logic [XLEN:0] snoop;
            snoop = cdb_snoop(data_tag_q[i], cdb_valid, cdb_tag, cdb_data);
            if (valid_q[i] && !data_rdy_q[i] && snoop[XLEN]) begin
                data_rdy_d[i] = 1'b1;
                data_d[i]     = snoop[XLEN-1:0];
            end else begin
                data_rdy_d[i] = data_rdy_d[i];
            end
            if (valid_q[i] && agu_valid && (tag_q[i] == agu_tag)) begin
                addr_rdy_d[i] = 1'b1;
                addr_d[i]     = agu_addr;
            end else begin
                addr_rdy_d[i] = addr_rdy_d[i];
            end
        end

        if (commit_ok_s) begin
            committed_d[commit_idx_s] = 1'b1;
            commit_ptr_d              = commit_ptr_q + PTR_W'(1);
        end else begin
            commit_ptr_d = commit_ptr_q;
        end

        // The tail slot is free, so none of the updates above touched it.
        if (alloc_fire_s) begin
            valid_d[tail_idx_s]     = 1'b1;
            committed_d[tail_idx_s] = 1'b0;
            tag_d[tail_idx_s]       = alloc_tag;
            data_tag_d[tail_idx_s]  = alloc_data_tag;
            if (agu_valid && (agu_tag == alloc_tag)) begin
                addr_rdy_d[tail_idx_s] = 1'b1;
                addr_d[tail_idx_s]     = agu_addr;
            end else begin
                addr_rdy_d[tail_idx_s] = 1'b0;
            end
            if (alloc_data_ready) begin
                data_rdy_d[tail_idx_s] = 1'b1;
                data_d[tail_idx_s]     = alloc_data;
            end else begin
                data_rdy_d[tail_idx_s] = alloc_snoop_s[XLEN];
                data_d[tail_idx_s]     = alloc_snoop_s[XLEN-1:0];
            end
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (drain_fire_s) begin
            valid_d[head_idx_s]     = 1'b0;
            committed_d[head_idx_s] = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        // Everything still uncommitted lies between commit_ptr_d and the tail.
        if (flush) begin
            valid_d = valid_d & committed_d;
            tail_d  = commit_ptr_d;
        end else begin
            valid_d = valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Pointer and entry state; reset discards everything, even undrained
    // committed stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= {PTR_W{1'b0}};
            commit_ptr_q <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            valid_q      <= {STQ_DEPTH{1'b0}};
            addr_rdy_q   <= {STQ_DEPTH{1'b0}};
            data_rdy_q   <= {STQ_DEPTH{1'b0}};
            committed_q  <= {STQ_DEPTH{1'b0}};
        end else begin
            head_q       <= head_d;
            commit_ptr_q <= commit_ptr_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            addr_rdy_q   <= addr_rdy_d;
            data_rdy_q   <= data_rdy_d;
            committed_q  <= committed_d;
        end
    end

    // Entry payload; only meaningful while the matching flag is set.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        data_q     <= data_d;
        data_tag_q <= data_tag_d;
        tag_q      <= tag_d;
    end

endmodule

// File: tb/tb_stq_buffer.sv
module tb_stq_buffer;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         cache_stall;
    logic         alloc_valid;
    logic [5:0]   alloc_tag;
    logic [5:0]   alloc_data_tag;
    logic         alloc_data_ready;
    logic [31:0]  alloc_data;
    logic         alloc_rdy;
    logic         agu_valid;
    logic [5:0]   agu_tag;
    logic [31:0]  agu_addr;
    logic [3:0]   cdb_valid;
    logic [23:0]  cdb_tag;
    logic [127:0] cdb_data;
    logic         commit_valid;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_data;
    logic         mem_req_ready;
    logic [31:0]  fwd_addr;
    logic         fwd_hit;
    logic [31:0]  fwd_data;
    logic         fwd_pending;
    logic [3:0]   count;

    int total;
    int bad;

    stq_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .alloc_data_tag(alloc_data_tag), .alloc_data_ready(alloc_data_ready),
        .alloc_data(alloc_data), .alloc_rdy(alloc_rdy),
        .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stores in program order, oldest at index 0.
    typedef struct {
        logic [5:0]  tag;
        logic [5:0]  dtag;
        logic        drdy;
        logic [31:0] data;
        logic        ardy;
        logic [31:0] addr;
        logic        cmt;
    } ent_t;

    ent_t q[$];
    logic exp_drain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; cache_stall = 1'b0;
        alloc_valid = 1'b0; alloc_tag = 6'd0; alloc_data_tag = 6'd0;
        alloc_data_ready = 1'b0; alloc_data = 32'd0;
        agu_valid = 1'b0; agu_tag = 6'd0; agu_addr = 32'd0;
        cdb_valid = 4'd0; cdb_tag = 24'd0; cdb_data = 128'd0;
        commit_valid = 1'b0; mem_req_ready = 1'b0; fwd_addr = 32'd0;
    endtask

    task automatic set_cdb(input int p, input logic [5:0] t, input logic [31:0] d);
        cdb_valid[p]       = 1'b1;
        cdb_tag[p*6 +: 6]  = t;
        cdb_data[p*32 +: 32] = d;
    endtask

    // Allocate a store whose address and data are both supplied this cycle.
    task automatic alloc_full(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
        alloc_valid = 1'b1; alloc_tag = t; alloc_data_tag = 6'd63;
        alloc_data_ready = 1'b1; alloc_data = d;
        agu_valid = 1'b1; agu_tag = t; agu_addr = a;
    endtask

    // Compare every DUT output against the model's view of the current cycle.
    task automatic check_now();
        logic        mv;
        logic        found;
        logic        fdrdy;
        logic [31:0] fdata;
        #1;
        chk("alloc_rdy", {31'd0, alloc_rdy}, {31'd0, q.size() < 8});
        chk("count", {28'd0, count}, q.size());
        mv = 1'b0;
        if (q.size() > 0) begin
            mv = q[0].cmt && q[0].ardy && q[0].drdy && !cache_stall;
        end
        chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, mv});
        if (mv) begin
            chk("mem_req_addr", mem_req_addr, {q[0].addr[31:2], 2'b00});
            chk("mem_req_data", mem_req_data, q[0].data);
        end
        found = 1'b0; fdrdy = 1'b0; fdata = 32'd0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && q[i].ardy && (q[i].addr[31:2] == fwd_addr[31:2])) begin
                found = 1'b1; fdrdy = q[i].drdy; fdata = q[i].data;
            end
        end
        chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, found && fdrdy});
        chk("fwd_pending", {31'd0, fwd_pending}, {31'd0, found && !fdrdy});
        if (found && fdrdy) chk("fwd_data", fwd_data, fdata);
        exp_drain = mv && mem_req_ready;
    endtask

    // Advance the model by one clock using the inputs held this cycle.
    task automatic model_update();
        ent_t e;
        int   nc;
        if (rst) begin
            q.delete();
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                if (!e.drdy) begin
                    for (int p = 0; p < 4; p++) begin
                        if (!e.drdy && cdb_valid[p] && cdb_tag[p*6 +: 6] == e.dtag) begin
                            e.drdy = 1'b1; e.data = cdb_data[p*32 +: 32];
                        end
                    end
                end
                if (agu_valid && e.tag == agu_tag) begin
                    e.ardy = 1'b1; e.addr = agu_addr;
                end
                q[i] = e;
            end
            if (commit_valid) begin
                nc = 0;
                while (nc < q.size() && q[nc].cmt) nc++;
                if (nc < q.size()) begin
                    e = q[nc]; e.cmt = 1'b1; q[nc] = e;
                end
            end
            if (alloc_valid && !flush && q.size() < 8) begin
                e.tag = alloc_tag; e.dtag = alloc_data_tag; e.cmt = 1'b0;
                e.ardy = agu_valid && (agu_tag == alloc_tag);
                e.addr = agu_addr;
                e.drdy = alloc_data_ready; e.data = alloc_data;
                for (int p = 0; p < 4; p++) begin
                    if (!e.drdy && cdb_valid[p] && cdb_tag[p*6 +: 6] == alloc_data_tag) begin
                        e.drdy = 1'b1; e.data = cdb_data[p*32 +: 32];
                    end
                end
                q.push_back(e);
            end
            if (exp_drain) void'(q.pop_front());
            if (flush) begin
                while (q.size() > 0 && !q[q.size()-1].cmt) void'(q.pop_back());
            end
        end
    endtask

    task automatic step();
        check_now();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q.delete();

        // Reset state
        rst = 1'b1;
        step();
        idle();

        // Basic store: alloc, address, commit, drain
        alloc_valid = 1'b1; alloc_tag = 6'd3; alloc_data_ready = 1'b1; alloc_data = 32'hAA;
        step(); idle();
        agu_valid = 1'b1; agu_tag = 6'd3; agu_addr = 32'h100;
        step(); idle();
        commit_valid = 1'b1; mem_req_ready = 1'b1;
        step(); idle();
        mem_req_ready = 1'b1;
        #1;
        chk("basic_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("basic_addr", mem_req_addr, 32'h100);
        chk("basic_data", mem_req_data, 32'hAA);
        step(); idle();
        #1;
        chk("basic_count", {28'd0, count}, 32'd0);

        // Fill to full, overflow attempt, drain one, then stream across wrap
        for (int i = 0; i < 8; i++) begin
            alloc_full(6'(10 + i), 32'h300 + 32'(4 * i), 32'(1000 + i));
            step(); idle();
        end
        #1;
        chk("full_alloc_rdy", {31'd0, alloc_rdy}, 32'd0);
        alloc_valid = 1'b1; alloc_tag = 6'd18; alloc_data_ready = 1'b1;
        step(); idle();
        chk("full_count", {28'd0, count}, 32'd8);
        commit_valid = 1'b1;
        step(); idle();
        mem_req_ready = 1'b1;
        step(); idle();
        #1;
        chk("pop_alloc_rdy", {31'd0, alloc_rdy}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            alloc_full(6'(40 + i), 32'h700 + 32'(4 * (i % 8)), 32'(2000 + i));
            commit_valid = 1'b1; mem_req_ready = 1'b1;
            step(); idle();
        end
        for (int i = 0; i < 30; i++) begin
            commit_valid = 1'b1; mem_req_ready = 1'b1;
            step(); idle();
        end
        #1;
        chk("wrap_drained", {28'd0, count}, 32'd0);

        // CDB capture after allocation
        alloc_valid = 1'b1; alloc_tag = 6'd20; alloc_data_tag = 6'd7;
        agu_valid = 1'b1; agu_tag = 6'd20; agu_addr = 32'h400;
        step(); idle();
        set_cdb(2, 6'd7, 32'h55);
        step(); idle();
        fwd_addr = 32'h400;
        #1;
        chk("cdb_late_hit", {31'd0, fwd_hit}, 32'd1);
        chk("cdb_late_data", fwd_data, 32'h55);
        step(); idle();
        // CDB capture in the allocation cycle; two ports match, port 2 wins
        alloc_valid = 1'b1; alloc_tag = 6'd21; alloc_data_tag = 6'd9;
        agu_valid = 1'b1; agu_tag = 6'd21; agu_addr = 32'h500;
        set_cdb(3, 6'd9, 32'h77);
        set_cdb(2, 6'd9, 32'h66);
        step(); idle();
        fwd_addr = 32'h500;
        #1;
        chk("cdb_same_hit", {31'd0, fwd_hit}, 32'd1);
        chk("cdb_same_data", fwd_data, 32'h66);
        step(); idle();
        flush = 1'b1;
        step(); idle();

        // Forwarding: youngest match wins; not-ready youngest gives pending
        alloc_full(6'd22, 32'h200, 32'd1);
        step(); idle();
        alloc_full(6'd23, 32'h200, 32'd2);
        step(); idle();
        fwd_addr = 32'h202;
        #1;
        chk("fwd_young_hit", {31'd0, fwd_hit}, 32'd1);
        chk("fwd_young_data", fwd_data, 32'd2);
        step(); idle();
        alloc_valid = 1'b1; alloc_tag = 6'd24; alloc_data_tag = 6'd30;
        agu_valid = 1'b1; agu_tag = 6'd24; agu_addr = 32'h200;
        step(); idle();
        fwd_addr = 32'h202;
        #1;
        chk("fwd_pend", {31'd0, fwd_pending}, 32'd1);
        chk("fwd_pend_hit", {31'd0, fwd_hit}, 32'd0);
        step(); idle();
        flush = 1'b1;
        step(); idle();

        // Flush with committed entries and a simultaneous (dropped) alloc
        for (int i = 0; i < 4; i++) begin
            alloc_full(6'(1 + i), 32'h600 + 32'(4 * i), 32'(3000 + i));
            step(); idle();
        end
        for (int i = 0; i < 2; i++) begin
            commit_valid = 1'b1;
            step(); idle();
        end
        flush = 1'b1;
        alloc_full(6'd5, 32'h610, 32'd3005);
        step(); idle();
        #1;
        chk("flush_count", {28'd0, count}, 32'd2);
        for (int i = 0; i < 2; i++) begin
            mem_req_ready = 1'b1;
            step(); idle();
        end
        #1;
        chk("flush_drained", {28'd0, count}, 32'd0);

        // Cache stall holds back an eligible head
        alloc_full(6'd6, 32'h800, 32'h1234);
        step(); idle();
        commit_valid = 1'b1;
        step(); idle();
        cache_stall = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk("stall_valid", {31'd0, mem_req_valid}, 32'd0);
        step(); idle();
        mem_req_ready = 1'b1;
        #1;
        chk("unstall_valid", {31'd0, mem_req_valid}, 32'd1);
        step(); idle();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            cache_stall = ($urandom_range(0, 4) == 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_tag   = 6'($urandom_range(0, 15));
            alloc_data_tag   = 6'($urandom_range(0, 15));
            alloc_data_ready = ($urandom_range(0, 2) == 0);
            alloc_data  = $urandom;
            agu_valid   = ($urandom_range(0, 1) == 1);
            agu_tag     = 6'($urandom_range(0, 15));
            agu_addr    = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            for (int p = 0; p < 4; p++) begin
                cdb_valid[p]         = ($urandom_range(0, 2) == 0);
                cdb_tag[p*6 +: 6]    = 6'($urandom_range(0, 15));
                cdb_data[p*32 +: 32] = $urandom;
            end
            commit_valid  = ($urandom_range(0, 9) < 3);
            mem_req_ready = ($urandom_range(0, 9) < 7);
            fwd_addr      = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            step();
        end
        idle();

        // Reset mid-operation discards committed but undrained stores
        alloc_full(6'd33, 32'h900, 32'd7);
        step(); idle();
        alloc_full(6'd34, 32'h904, 32'd8);
        commit_valid = 1'b1;
        step(); idle();
        rst = 1'b1;
        step(); idle();
        #1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_alloc_rdy", {31'd0, alloc_rdy}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
